vscale_dmem_bridge: RTL and testbench
=====================================

Name: vscale_dmem_bridge

Overview:
- Parametrised bridge between the vscale pipeline data-memory port and the core_top data request/acknowledge bus (d_req_*, d_ack_*).
- Captures the address phase, merges in the one-cycle-delayed write data, and holds the request until it is acknowledged.
- Adds alignment checking, a bus timeout, and error signalling on core_badmem_e, which the current direct wiring ties to 0.
- Sits inside core_top between vscale_pipeline and the d_req_* ports.

Parameters:
- ADDR_WIDTH, 32, width of core_addr and d_req_addr.
- DATA_WIDTH, 32, data path width; 32 or 64 only.
- TIMEOUT, 256, cycles a request may wait for d_req_ack before abort; 0 disables the timeout.
- CHECK_ALIGN, 1, 1 enables the misalignment check; 0 passes every access to the bus.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- core_en  in  1  data access request (address phase).
- core_wen  in  1  1 = store, 0 = load.
- core_size  in  3  vscale memory type; bits [1:0] give log2(bytes).
- core_addr  in  ADDR_WIDTH  access address.
- core_wdata_delayed  in  DATA_WIDTH  store data, valid the cycle after acceptance.
- core_wait  out  1  stall to the pipeline.
- core_rdata  out  DATA_WIDTH  load data.
- core_badmem_e  out  1  one-cycle error pulse.
- d_req_val  out  1  bus request valid.
- d_req_addr  out  ADDR_WIDTH  bus address.
- d_req_cop  out  3  3'b000 read, 3'b001 write.
- d_req_wdata  out  DATA_WIDTH  bus write data.
- d_req_size  out  3  copy of core_size.
- d_req_ack  in  1  bus acknowledge; completes the request.
- d_ack_rdata  in  DATA_WIDTH  read data, valid with d_req_ack.
- err_count  out  16  saturating count of errors.

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, state IDLE, timeout counter 0, err_count 0.
- States: IDLE, REQ, ERR.
- Accept window: a command is accepted when core_en=1 and the state is IDLE, or the state is REQ with d_req_ack=1 (back-to-back).
  - On acceptance, register core_addr, core_wen and core_size.
  - Check for misalignment: with CHECK_ALIGN=1, an access is misaligned if addr & ((1<<size[1:0])-1) != 0.
  - Check for an illegal size: size[1:0]=3 with DATA_WIDTH=32 is illegal regardless of CHECK_ALIGN.
  - Legal access: go to REQ. Misaligned or illegal access: go to ERR; no bus request is ever issued.
- REQ, first cycle: d_req_wdata is registered from core_wdata_delayed (the store data arrives then).
- REQ, every cycle:
  - d_req_val=1.
  - d_req_addr, d_req_cop and d_req_size come from the registered command and are held stable until the ack.
  - For a write, d_req_wdata is held stable until the ack.
- Wait and read data:
  - core_wait = (state==REQ) && !d_req_ack.
  - core_rdata = d_ack_rdata in the ack cycle of a read. At all other times core_rdata holds its last value (registered copy, no combinational glitch to 0).
- REQ + d_req_ack: the request completes. Next state is REQ if a new command is accepted in the same cycle, else IDLE. The timeout counter clears.
- Timeout (TIMEOUT>0):
  - The counter increments each REQ cycle without an ack.
  - When the counter reaches TIMEOUT-1 with no ack, the next state is ERR.
  - An ack in that same cycle wins: normal completion, no error.
- ERR: lasts exactly 1 cycle.
  - core_badmem_e=1, d_req_val=0, core_wait=0, core_rdata=0.
  - err_count increments, saturating at 16'hFFFF.
  - Returns to IDLE; core_en is not accepted in ERR.
- Simultaneous events: only one request is outstanding. core_en while in REQ without ack is ignored, because the pipeline is stalled by core_wait.
- Reset mid-request: d_req_val drops asynchronously; a late d_req_ack arriving in IDLE is ignored.
- Widths: core_rdata and d_req_wdata are passed through unaltered. Byte-lane placement and sign extension remain the pipeline's job.

Test Plan:
- Load word at 0x100, ack on 3rd REQ cycle with rdata 0xDEADBEEF -> d_req_val high 3 cycles, cop=000, core_wait high 2 cycles, core_rdata=0xDEADBEEF in ack cycle.
- Store size=1 to 0x202, wdata 0x1234 presented the cycle after en, immediate ack -> d_req_cop=001, d_req_wdata=0x1234, d_req_size=1, core_wait never high.
- Word access to 0x103 with CHECK_ALIGN=1 -> no d_req_val; core_badmem_e pulse 1 cycle after en; err_count=1.
- TIMEOUT=4, no ack -> d_req_val high 4 cycles, then ERR: core_badmem_e=1, core_wait=0, err_count increments. Repeat with ack in the 4th cycle -> no error.
- Back-to-back: ack of a load at 0x10 with core_en for a store at 0x14 in the same cycle -> REQ held, d_req_addr changes to 0x14 the next cycle, no IDLE gap.
- Assert reset during REQ -> all outputs 0 immediately. A d_req_ack afterwards produces no state change and no badmem pulse.

Source files
------------

// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge
//   Bridge between the vscale pipeline data-memory port and the core_top
//   d_req_* / d_ack_* request/acknowledge bus. It captures the address
//   phase, merges in the store data that arrives one cycle later, and holds
//   the bus request until it is acknowledged. Misaligned or illegal accesses
//   and bus timeouts produce a one-cycle core_badmem_e pulse and bump a
//   saturating error counter.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   core_en/wen/size/addr pipeline address phase
//   core_wdata_delayed    store data, valid the cycle after acceptance
//   core_wait             pipeline stall while a request is outstanding
//   core_rdata            load data (held between loads)
//   core_badmem_e         one-cycle error pulse
//   d_req_val/addr/cop/wdata/size   bus request
//   d_req_ack, d_ack_rdata          bus acknowledge and read data
//   err_count             saturating error count
module vscale_dmem_bridge #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = 256,
    parameter int CHECK_ALIGN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_en,
    input  logic                  core_wen,
    input  logic [2:0]            core_size,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata_delayed,
    output logic                  core_wait,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_badmem_e,
    output logic                  d_req_val,
    output logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic [2:0]            d_req_cop,
    output logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic [2:0]            d_req_size,
    input  logic                  d_req_ack,
    input  logic [DATA_WIDTH-1:0] d_ack_rdata,
    output logic [15:0]           err_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [2:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  first_q, first_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [15:0]           err_count_q, err_count_d;

    logic accept;
    logic misaligned;
    logic illegal;
    logic bad_cmd;
    logic timeout_hit;
    logic read_ack;

    always_comb begin
        // Alignment check on the incoming command; size[1:0] is log2(bytes).
        misaligned = 1'b0;
        case (core_size[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = core_addr[0];
            2'd2:    misaligned = |core_addr[1:0];
            default: misaligned = |core_addr[2:0];
        endcase
        if (CHECK_ALIGN == 0) begin
            misaligned = 1'b0;
        end
        illegal = (core_size[1:0] == 2'd3) && (DATA_WIDTH == 32);
        bad_cmd = misaligned || illegal;

        // Back-to-back: a command may be taken in the ack cycle of the previous one.
        accept      = core_en && ((state_q == IDLE) || ((state_q == REQ) && d_req_ack));
        timeout_hit = (TIMEOUT > 0) && (tmo_q == TW'(TIMEOUT - 1));
        read_ack    = (state_q == REQ) && d_req_ack && !wen_q;

        state_d     = state_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        first_d     = 1'b0;
        tmo_d       = tmo_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (accept) begin
                    state_d = bad_cmd ? ERR : REQ;
                end
            end
            REQ: begin
                if (d_req_ack) begin
                    tmo_d   = '0;
                    state_d = accept ? (bad_cmd ? ERR : REQ) : IDLE;
                end else if (timeout_hit) begin
                    tmo_d   = '0;
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ERR: begin
                state_d = IDLE;
                rdata_d = '0;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            addr_d  = core_addr;
            wen_d   = core_wen;
            size_d  = core_size;
            first_d = !bad_cmd;
        end

        // Store data lands during the first REQ cycle.
        if (first_q) begin
            wdata_d = core_wdata_delayed;
        end

        if (read_ack) begin
            rdata_d = d_ack_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            size_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            first_q     <= 1'b0;
            tmo_q       <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            first_q     <= first_d;
            tmo_q       <= tmo_d;
            err_count_q <= err_count_d;
        end
    end

    assign d_req_val     = (state_q == REQ);
    assign d_req_addr    = addr_q;
    assign d_req_cop     = {2'b00, wen_q};
    assign d_req_size    = size_q;
    // In the first REQ cycle the store data is still on the input, so forward
    // it; an immediate ack then sees valid write data.
    assign d_req_wdata   = first_q ? core_wdata_delayed : wdata_q;
    assign core_wait     = (state_q == REQ) && !d_req_ack;
    assign core_badmem_e = (state_q == ERR);
    assign core_rdata    = (state_q == ERR) ? '0 :
                           read_ack         ? d_ack_rdata : rdata_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
module tb_vscale_dmem_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_en;
    logic        core_wen;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wdata_delayed;
    logic        core_wait;
    logic [31:0] core_rdata;
    logic        core_badmem_e;
    logic        d_req_val;
    logic [31:0] d_req_addr;
    logic [2:0]  d_req_cop;
    logic [31:0] d_req_wdata;
    logic [2:0]  d_req_size;
    logic        d_req_ack;
    logic [31:0] d_ack_rdata;
    logic [15:0] err_count;

    int errors = 0;
    int checks = 0;

    // Transaction-level reference state.
    logic [31:0] rdata_m;
    logic [15:0] errcnt_m;

    vscale_dmem_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO), .CHECK_ALIGN(1)
    ) dut (
        .clk(clk), .reset(reset),
        .core_en(core_en), .core_wen(core_wen), .core_size(core_size),
        .core_addr(core_addr), .core_wdata_delayed(core_wdata_delayed),
        .core_wait(core_wait), .core_rdata(core_rdata), .core_badmem_e(core_badmem_e),
        .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop),
        .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
        .d_req_ack(d_req_ack), .d_ack_rdata(d_ack_rdata), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_val"}, d_req_val, 0);
        chk({tag, "_wait"}, core_wait, 0);
        chk({tag, "_bad"}, core_badmem_e, 0);
        chk({tag, "_rdata"}, core_rdata, rdata_m);
        chk({tag, "_errcnt"}, err_count, errcnt_m);
        @(posedge clk); #1;
    endtask

    task automatic expect_err(input string tag);
        @(negedge clk);
        chk({tag, "_err_bad"}, core_badmem_e, 1);
        chk({tag, "_err_val"}, d_req_val, 0);
        chk({tag, "_err_wait"}, core_wait, 0);
        chk({tag, "_err_rdata"}, core_rdata, 0);
        @(posedge clk); #1;
        if (errcnt_m != 16'hFFFF) errcnt_m++;
        rdata_m = '0;
        chk({tag, "_errcnt"}, err_count, errcnt_m);
    endtask

    // One complete access from IDLE. ack_at is the REQ cycle (1-based) in
    // which the bus acknowledges; 0 or beyond the timeout means never.
    task automatic do_access(input string tag, input logic [31:0] addr, input bit wen,
                             input logic [2:0] size, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int ack_at);
        bit bad;
        bit done;
        bit ack;
        bad  = (size[1:0] == 2'd3) || ((addr % (32'd1 << size[1:0])) != 0);
        done = 1'b0;
        core_en = 1'b1; core_wen = wen; core_size = size; core_addr = addr;
        d_req_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_acc_val"}, d_req_val, 0);
        chk({tag, "_acc_wait"}, core_wait, 0);
        @(posedge clk); #1;
        core_en = 1'b0; core_addr = $urandom; core_wen = 1'($urandom);
        core_size = 3'($urandom); core_wdata_delayed = wdata;
        if (bad) begin
            expect_err(tag);
        end else begin
            for (int k = 1; k <= TMO; k++) begin
                ack = (k == ack_at);
                d_req_ack = ack;
                d_ack_rdata = ack ? rdata : $urandom;
                @(negedge clk);
                chk({tag, "_val"}, d_req_val, 1);
                chk({tag, "_addr"}, d_req_addr, addr);
                chk({tag, "_cop"}, d_req_cop, {2'b00, wen});
                chk({tag, "_size"}, d_req_size, size);
                chk({tag, "_wait"}, core_wait, !ack);
                chk({tag, "_bad"}, core_badmem_e, 0);
                if (wen) chk({tag, "_wdata"}, d_req_wdata, wdata);
                chk({tag, "_rdata"}, core_rdata, (ack && !wen) ? rdata : rdata_m);
                @(posedge clk); #1;
                core_wdata_delayed = $urandom;
                if (ack) begin
                    done = 1'b1;
                    break;
                end
            end
            d_req_ack = 1'b0;
            if (!done) expect_err(tag);
            else if (!wen) rdata_m = rdata;
        end
        chk_idle({tag, "_idle"});
    endtask

    initial begin
        reset = 1'b1;
        core_en = 0; core_wen = 0; core_size = 0; core_addr = 0;
        core_wdata_delayed = 0; d_req_ack = 0; d_ack_rdata = 0;
        rdata_m = 0; errcnt_m = 0;
        #12;
        chk("rst_val", d_req_val, 0);
        chk("rst_wait", core_wait, 0);
        chk("rst_bad", core_badmem_e, 0);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_addr", d_req_addr, 0);
        chk("rst_wdata", d_req_wdata, 0);
        chk("rst_errcnt", err_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_access("load_word", 32'h100, 0, 3'd2, 32'h0, 32'hDEADBEEF, 3);
        do_access("store_half", 32'h202, 1, 3'd1, 32'h1234, 32'h0, 1);
        do_access("misalign", 32'h103, 0, 3'd2, 32'h0, 32'h0, 1);
        do_access("timeout", 32'h300, 0, 3'd2, 32'h0, 32'hAAAA5555, 0);
        do_access("ack_last", 32'h304, 1, 3'd2, 32'hCAFEF00D, 32'h0, TMO);
        do_access("dword32", 32'h308, 0, 3'd3, 32'h0, 32'h0, 1);

        // Back-to-back: load at 0x10 acked while a store to 0x14 is presented.
        core_en = 1; core_wen = 0; core_size = 3'd2; core_addr = 32'h10;
        @(posedge clk); #1;
        core_wen = 1; core_addr = 32'h14; core_wdata_delayed = $urandom;
        d_req_ack = 1; d_ack_rdata = 32'h01020304;
        @(negedge clk);
        chk("b2b_ld_addr", d_req_addr, 32'h10);
        chk("b2b_ld_rdata", core_rdata, 32'h01020304);
        chk("b2b_ld_wait", core_wait, 0);
        @(posedge clk); #1;
        rdata_m = 32'h01020304;
        core_en = 0; core_wdata_delayed = 32'h55667788; d_req_ack = 0;
        @(negedge clk);
        chk("b2b_st_val", d_req_val, 1);
        chk("b2b_st_addr", d_req_addr, 32'h14);
        chk("b2b_st_cop", d_req_cop, 3'b001);
        chk("b2b_st_wdata", d_req_wdata, 32'h55667788);
        chk("b2b_st_wait", core_wait, 1);
        @(posedge clk); #1;
        core_wdata_delayed = $urandom; d_req_ack = 1;
        @(negedge clk);
        chk("b2b_st_hold", d_req_wdata, 32'h55667788);
        chk("b2b_st_rdata", core_rdata, rdata_m);
        @(posedge clk); #1;
        d_req_ack = 0;
        chk_idle("b2b_idle");

        // Randomised accesses against the transaction model.
        for (int i = 0; i < 40; i++) begin
            do_access("rnd", $urandom & 32'hFFF, 1'($urandom),
                      {1'($urandom), 2'($urandom_range(0, 3))},
                      $urandom, $urandom, $urandom_range(0, TMO + 1));
        end

        // Reset in the middle of a request.
        core_en = 1; core_wen = 0; core_size = 3'd2; core_addr = 32'h40;
        @(posedge clk); #1;
        core_en = 0;
        @(negedge clk);
        chk("mid_val_pre", d_req_val, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_val", d_req_val, 0);
        chk("mid_wait", core_wait, 0);
        chk("mid_bad", core_badmem_e, 0);
        chk("mid_rdata", core_rdata, 0);
        chk("mid_addr", d_req_addr, 0);
        chk("mid_errcnt", err_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        rdata_m = 0; errcnt_m = 0;
        d_req_ack = 1; d_ack_rdata = $urandom;
        @(negedge clk);
        chk("late_ack_val", d_req_val, 0);
        chk("late_ack_bad", core_badmem_e, 0);
        chk("late_ack_rdata", core_rdata, 0);
        @(posedge clk); #1;
        d_req_ack = 0;
        chk_idle("late_ack_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
